// File: rtl/nou_axi_wr_slave_ctl.sv
// nou_axi_wr_slave_ctl
//
// AXI write-channel responder on the NOU receive side. It accepts single-beat
// AXI writes and pairs each AW address with its W beat. Each pair becomes one
// flit of a packet: header flits first, then data flits. One B response is
// issued per accepted beat.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   header_flit_num_i     header flits per packet (>=1), sampled on first beat
//   data_flit_num_i       data flits per packet (0 allowed), sampled likewise
//   axi_aw*_i/_o          AW channel (valid/ready/address)
//   axi_w*_i/_o           W channel (valid/ready/data), WLAST not used
//   axi_b*_i/_o           B channel (valid/ready/response)
//   flit_*                flit output stream (valid/ready/data/is_head/last)
//   pkt_addr_o            AW address of the first data flit of the packet
//   pkt_done_o            pulse when the last flit is taken downstream
//   dbg_state_o           packet FSM state (0 IDLE, 1 HEAD, 2 DATA)
//
// Handshakes: a transfer happens on any rising clock edge where valid and
// ready are both high; valid never depends on ready.
//
// Optional feature macro: NOU_AW_SLV_ADDR_CHK_EN. When defined, every beat
// after the first of a packet must be at the previous address + DATA_W/8;
// a mismatching beat is still forwarded but answered with SLVERR.
module nou_axi_wr_slave_ctl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int HCNT_W = 4,
  parameter int DCNT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [HCNT_W-1:0] header_flit_num_i,
  input  logic [DCNT_W-1:0] data_flit_num_i,
  input  logic              axi_awvld_i,
  output logic              axi_awrdy_o,
  input  logic [ADDR_W-1:0] axi_awaddr_i,
  input  logic              axi_wvld_i,
  output logic              axi_wrdy_o,
  input  logic [DATA_W-1:0] axi_wdata_i,
  output logic              axi_bvld_o,
  input  logic              axi_brdy_i,
  output logic [1:0]        axi_bresp_o,
  output logic              flit_vld_o,
  input  logic              flit_rdy_i,
  output logic [DATA_W-1:0] flit_data_o,
  output logic              flit_is_head_o,
  output logic              flit_last_o,
  output logic [ADDR_W-1:0] pkt_addr_o,
  output logic              pkt_done_o,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W = (HCNT_W > DCNT_W) ? HCNT_W : DCNT_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    beat_cnt_q;
  logic [HCNT_W-1:0]   hnum_q;
  logic [DCNT_W-1:0]   dnum_q;

  logic                aw_full_q;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic                w_full_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [3:0]          b_cnt_q;
  logic [3:0]          b_cnt_d;

  logic                flit_vld_q;
  logic [DATA_W-1:0]   flit_data_q;
  logic                flit_head_q;
  logic                flit_last_q;
  logic [ADDR_W-1:0]   pkt_addr_q;

  logic                aw_hs;
  logic                w_hs;
  logic                b_hs;
  logic                fire;

  assign axi_awrdy_o = ~aw_full_q;
  assign axi_wrdy_o  = ~w_full_q;
  assign aw_hs       = axi_awvld_i & ~aw_full_q;
  assign w_hs        = axi_wvld_i & ~w_full_q;
  assign b_hs        = (b_cnt_q != 4'h0) & axi_brdy_i;

  // A beat moves out only when both halves are present, the flit register
  // is free (or being drained this cycle) and the B counter has room.
  assign fire = aw_full_q & w_full_q & (~flit_vld_q | flit_rdy_i) &
                (b_cnt_q != 4'hF);

  always_comb begin
    b_cnt_d = b_cnt_q;
    if (fire & ~b_hs) begin
      b_cnt_d = b_cnt_q + 4'd1;
    end else if (~fire & b_hs) begin
      b_cnt_d = b_cnt_q - 4'd1;
    end
  end

  // Holding slots and B counter. A slot can only load while empty and only
  // empties on fire, so load and clear never coincide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      b_cnt_q   <= 4'h0;
    end else begin
      b_cnt_q <= b_cnt_d;
      if (fire) begin
        aw_full_q <= 1'b0;
      end else if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= axi_awaddr_i;
      end
      if (fire) begin
        w_full_q <= 1'b0;
      end else if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= axi_wdata_i;
      end
    end
  end

  // Packet FSM with the flit output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      hnum_q      <= '0;
      dnum_q      <= '0;
      flit_vld_q  <= 1'b0;
      flit_data_q <= '0;
      flit_head_q <= 1'b0;
      flit_last_q <= 1'b0;
      pkt_addr_q  <= '0;
    end else if (fire) begin
      flit_vld_q  <= 1'b1;
      flit_data_q <= w_data_q;
      flit_last_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          hnum_q      <= header_flit_num_i;
          dnum_q      <= data_flit_num_i;
          flit_head_q <= 1'b1;
          if (header_flit_num_i <= HCNT_W'(1)) begin
            beat_cnt_q <= '0;
            if (data_flit_num_i == '0) begin
              flit_last_q <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            state_q    <= S_HEAD;
            beat_cnt_q <= CNT_W'(1);
          end
        end
        S_HEAD: begin
          flit_head_q <= 1'b1;
          if (beat_cnt_q == CNT_W'(hnum_q) - CNT_W'(1)) begin
            beat_cnt_q <= '0;
            if (dnum_q == '0) begin
              flit_last_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          flit_head_q <= 1'b0;
          if (beat_cnt_q == '0) begin
            pkt_addr_q <= aw_addr_q;
          end
          if (beat_cnt_q == CNT_W'(dnum_q) - CNT_W'(1)) begin
            flit_last_q <= 1'b1;
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
          end else begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q    <= S_IDLE;
          beat_cnt_q <= '0;
        end
      endcase
    end else if (flit_rdy_i) begin
      flit_vld_q <= 1'b0;
    end
  end

  assign flit_vld_o     = flit_vld_q;
  assign flit_data_o    = flit_data_q;
  assign flit_is_head_o = flit_head_q;
  assign flit_last_o    = flit_last_q;
  assign pkt_addr_o     = pkt_addr_q;
  assign pkt_done_o     = flit_vld_q & flit_rdy_i & flit_last_q;
  assign axi_bvld_o     = (b_cnt_q != 4'h0);
  assign dbg_state_o    = state_q;

`ifdef NOU_AW_SLV_ADDR_CHK_EN
  // One error bit per outstanding B response; b_cnt never exceeds 15, so
  // 16 entries cannot overflow.
  logic [15:0]       err_fifo_q;
  logic [3:0]        err_wr_q;
  logic [3:0]        err_rd_q;
  logic [ADDR_W-1:0] prev_addr_q;
  logic              addr_err;

  // A fire from IDLE is the first beat of a packet and is never checked.
  assign addr_err = (state_q != S_IDLE) &&
                    (aw_addr_q != prev_addr_q + ADDR_W'(DATA_W / 8));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_fifo_q  <= '0;
      err_wr_q    <= 4'h0;
      err_rd_q    <= 4'h0;
      prev_addr_q <= '0;
    end else begin
      if (fire) begin
        err_fifo_q[err_wr_q] <= addr_err;
        err_wr_q             <= err_wr_q + 4'd1;
        prev_addr_q          <= aw_addr_q;
      end
      if (b_hs) begin
        err_rd_q <= err_rd_q + 4'd1;
      end
    end
  end

  assign axi_bresp_o = err_fifo_q[err_rd_q] ? 2'b10 : 2'b00;
`else
  assign axi_bresp_o = 2'b00;
`endif

endmodule

// File: doc/nou_axi_wr_slave_ctl.md
# nou_axi_wr_slave_ctl

AXI write-channel responder on the NOU receive side: the counterpart of the NOU AW master controller. It accepts single-beat AXI writes, pairs each AW address with its W data beat, and reassembles them into a packet flit stream of header flits followed by data flits. It issues one B response per accepted beat and sits between the NOU AXI slave port and the packet ingress buffer.

## Interface
Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 64, AXI data and flit width
- HCNT_W, 4, header flit count width
- DCNT_W, 8, data flit count width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- header_flit_num  in  HCNT_W  header flits per packet, ≥1; sampled on a packet's first beat
- data_flit_num  in  DCNT_W  data flits per packet, 0 allowed; sampled on the same beat
- axi_awvld / axi_awrdy  in / out  1  AW handshake
- axi_awaddr  in  ADDR_W  write address
- axi_wvld / axi_wrdy  in / out  1  W handshake
- axi_wdata  in  DATA_W  write data; WLAST ignored, all bursts are one beat
- axi_bvld / axi_brdy  out / in  1  B handshake
- axi_bresp  out  2  B response
- flit_vld / flit_rdy  out / in  1  flit output handshake
- flit_data  out  DATA_W  flit payload
- flit_is_head  out  1  flit is a header flit
- flit_last  out  1  last flit of the packet
- pkt_addr  out  ADDR_W  AW address of the first data flit of the current packet
- pkt_done  out  1  one-cycle pulse when the last flit is accepted downstream

## Operation
- One AW holding slot and one W holding slot. axi_awrdy = ~aw_full; axi_wrdy = ~w_full. AW and W are accepted independently, in either order.
- fire = aw_full & w_full & (~flit_vld | flit_rdy) & (b_cnt != 15).
  - On fire, both slots clear.
  - The flit output register loads {wdata, is_head, last}.
  - b_cnt increments.
- B counter b_cnt is 4 bits. axi_bvld = (b_cnt != 0); a B handshake decrements it. A fire and a B handshake in the same cycle leave b_cnt unchanged.
- FSM states are IDLE, HEAD and DATA. beat_cnt counts fires within the current phase.
  - IDLE, fire: latch hnum = header_flit_num and dnum = data_flit_num. The flit is a header.
    - hnum == 1 and dnum == 0: last = 1, stay in IDLE.
    - hnum == 1 and dnum > 0: go to DATA.
    - Otherwise: go to HEAD with beat_cnt = 1.
  - HEAD, fire: the flit is a header. When beat_cnt == hnum-1, go to DATA (or to IDLE with last = 1 if dnum == 0), beat_cnt = 0. Otherwise beat_cnt increments.
  - DATA, fire: the flit is data. The first data beat (beat_cnt == 0) loads pkt_addr from the AW slot. When beat_cnt == dnum-1, last = 1, go to IDLE, beat_cnt = 0.
- flit_vld is cleared by flit_rdy unless a fire happens in the same cycle.
- pkt_done = flit_vld & flit_rdy & flit_last.
- axi_bresp = OKAY (2'b00) unless the address check is enabled (see Configuration).

## Timing
- Reset values: axi_awrdy = 1 and axi_wrdy = 1 (slots empty). All other outputs are 0. State is IDLE and all counters are 0.
- Latency: AW and W handshaked in cycle 0 → fire in cycle 1 → flit_vld and axi_bvld are high in cycle 2.
- Peak throughput is one beat per 2 cycles, because the slots refill the cycle after a fire.
- When b_cnt == 15 (B channel saturated), fire stalls and both holding slots stay full.
- Downstream backpressure (flit_rdy = 0) stalls fire. AXI backpressure follows through the full holding slots.
- rst asserted mid-packet discards held beats, the pending flit and pending B responses, and returns the FSM to IDLE. No pkt_done is generated.

## Configuration
- NOU_AW_SLV_ADDR_CHK_EN
  - Defined:
    - Each beat after the first in a packet must have awaddr equal to the previous address + DATA_W/8.
    - A mismatching beat still fires but its B response is SLVERR (2'b10). The SLVERR flag is queued alongside b_cnt in a 16-entry 1-bit FIFO.
    - The first beat of a packet never mismatches.
  - Undefined: no comparison is made, axi_bresp is constant 2'b00, and no FIFO is present.

## Test plan
- hnum=2, dnum=3, addresses 0x100..0x120 step 8, flit_rdy=1 → 5 flits with is_head 1,1,0,0,0; flit_last on the 5th; pkt_addr=0x110; pkt_done one cycle; 5 OKAY B responses.
- hnum=1, dnum=0 → one flit with is_head=1 and last=1; FSM stays in IDLE; next packet starts as a header.
- W arrives 3 cycles before AW → axi_wrdy low after acceptance; the flit appears 2 cycles after the AW handshake.
- axi_brdy=0 for 20 beats → exactly 15 fires; axi_awrdy and axi_wrdy drop once the slots fill. brdy=1 drains 15 B responses, then traffic resumes.
- rst pulsed after 2 of 4 flits with flit_rdy=0 → all outputs return to reset values next cycle; no pkt_done; a new packet is handled correctly.
- With NOU_AW_SLV_ADDR_CHK_EN, 3rd beat address +16 → that B is 2'b10 and all others 2'b00; the flit is still delivered.
